// File: rtl/fifo_out_ctrl_if.sv
// Handshake and status bundle between the factorial top-level and the output FIFO controller.
// The controller sits on the slave side; the top-level drives requests through master.
interface fifo_out_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 6
) ();
    logic              wr_en;
    logic              rd_en;
    logic              reg_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_ack;
    logic              wr_err;
    logic              rd_ack;
    logic              rd_err;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  data_count;
    logic [2:0]        state;

    modport master (
        output wr_en, rd_en,
        input  reg_we, wr_addr, rd_addr, wr_ack, wr_err, rd_ack, rd_err,
        input  full, empty, data_count, state
    );

    modport slave (
        input  wr_en, rd_en,
        output reg_we, wr_addr, rd_addr, wr_ack, wr_err, rd_ack, rd_err,
        output full, empty, data_count, state
    );
endinterface

// File: rtl/fifo_out_ctrl.sv
// Sequencing controller for the 32-entry output FIFO: pointers, occupancy, register-file
// write strobe/address, registered read-mux select, handshake acks/errors and a debug FSM.
module fifo_out_ctrl #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic           clk,
    input  logic           reset,
    fifo_out_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        StInit    = 3'b000,
        StNoOp    = 3'b001,
        StWrite   = 3'b010,
        StWrError = 3'b011,
        StRead    = 3'b100,
        StRdError = 3'b101,
        StRw      = 3'b110,
        StUnused  = 3'b111
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              wr_ack_q, wr_ack_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_ack_q, rd_ack_d;
    logic              rd_err_q, rd_err_d;

    logic accept_en;
    logic push_ok;
    logic pop_ok;
    logic wr_rej;
    logic rd_rej;

    // Requests in a reset cycle or in the illegal state are discarded, so the register file
    // never sees a write strobe that the pointers do not account for.
    assign accept_en = ~reset & (state_q != StUnused);
    assign push_ok   = accept_en & bus.wr_en & ~full_q;
    assign pop_ok    = accept_en & bus.rd_en & ~empty_q;
    assign wr_rej    = accept_en & bus.wr_en & full_q;
    assign rd_rej    = accept_en & bus.rd_en & empty_q;

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        rd_addr_d = rd_addr_q;
        count_d   = count_q;

        if (push_ok) begin
            tail_d = tail_q + ADDR_W'(1);
        end
        if (pop_ok) begin
            rd_addr_d = head_q;
            head_d    = head_q + ADDR_W'(1);
        end

        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d   = (count_d == CNT_W'(DEPTH));
        empty_d  = (count_d == '0);
        wr_ack_d = push_ok;
        wr_err_d = wr_rej;
        rd_ack_d = pop_ok;
        rd_err_d = rd_rej;
    end

    // Mixed requests are classified by the side that was rejected, so a debug trace shows
    // the error even when the other half of the request went through.
    always_comb begin
        state_d = StNoOp;
        if (state_q == StUnused) begin
            state_d = StInit;
        end else if (push_ok && pop_ok) begin
            state_d = StRw;
        end else if (push_ok && rd_rej) begin
            state_d = StRdError;
        end else if (pop_ok && wr_rej) begin
            state_d = StWrError;
        end else if (push_ok) begin
            state_d = StWrite;
        end else if (pop_ok) begin
            state_d = StRead;
        end else if (wr_rej) begin
            state_d = StWrError;
        end else if (rd_rej) begin
            state_d = StRdError;
        end else begin
            state_d = StNoOp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || (state_q == StUnused)) begin
            state_q   <= StInit;
            head_q    <= '0;
            tail_q    <= '0;
            rd_addr_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            wr_ack_q  <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            rd_addr_q <= rd_addr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            wr_ack_q  <= wr_ack_d;
            wr_err_q  <= wr_err_d;
            rd_ack_q  <= rd_ack_d;
            rd_err_q  <= rd_err_d;
        end
    end

    assign bus.reg_we     = push_ok;
    assign bus.wr_addr    = tail_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.wr_ack     = wr_ack_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.rd_ack     = rd_ack_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.data_count = count_q;
    assign bus.state      = state_q;

endmodule
